// File: rtl/truth_table_probe_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_probe_pkg
// Shared types and constants for the truth-table probe: FSM state encoding,
// default geometry (4 inputs, 2 settle cycles), the default reference table
// and width helpers used by the interface and the top module.
// -----------------------------------------------------------------------------
package truth_table_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 2;
    localparam int TT_W       = 2 ** N_IN_DEF;
    localparam int CNT_W      = $clog2(SETTLE_DEF + 1);

    localparam logic [15:0] EXPECTED_DEF = 16'h429B;

    // Truth-table width for an n-input gate.
    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    // Settle counter width; never below one bit so SETTLE=0 still elaborates.
    function automatic int cnt_w(input int s);
        return (s < 1) ? 1 : $clog2(s + 1);
    endfunction

endpackage

// File: rtl/truth_table_probe_if.sv
// -----------------------------------------------------------------------------
// truth_table_probe_if
// Groups the probe's control handshake and gate-facing signals.
//   start   : sweep request (master -> probe)
//   resp_i  : gate output (master/gate -> probe)
//   busy    : sweep in progress
//   done    : one-cycle completion pulse
//   vec_o   : gate input vector
//   table_o : assembled truth table
//   match   : table equals the reference
//   err_cnt : number of mismatching table bits
// Modports: slave = the probe, master = the environment driving it.
// -----------------------------------------------------------------------------
interface truth_table_probe_if
    import truth_table_probe_pkg::*;
#(
    parameter int N_IN = 4
);
    logic                      start;
    logic                      resp_i;
    logic                      busy;
    logic                      done;
    logic [N_IN-1:0]           vec_o;
    logic [tt_w(N_IN)-1:0]     table_o;
    logic                      match;
    logic [N_IN:0]             err_cnt;

    modport slave (
        input  start, resp_i,
        output busy, done, vec_o, table_o, match, err_cnt
    );

    modport master (
        output start, resp_i,
        input  busy, done, vec_o, table_o, match, err_cnt
    );
endinterface

// File: rtl/truth_table_probe_settle_timer.sv
// -----------------------------------------------------------------------------
// probe_settle_timer
// Loadable down-counter with a zero flag; times the settle window of each
// vector slot.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_load_val (has priority over decrement)
//   i_load_val  : value loaded at the start of a slot
//   i_dec       : decrement request; the counter stops at zero
//   o_zero      : counter is zero
// -----------------------------------------------------------------------------
module probe_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/truth_table_probe.sv
// -----------------------------------------------------------------------------
// truth_table_probe
// Sweeps every input combination of a single-output gate, waits SETTLE idle
// cycles per vector, samples the gate output and builds the 2^N_IN-bit truth
// table, then reports match / mismatch count against EXPECTED.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : truth_table_probe_if.slave (start, resp_i, busy, done, vec_o,
//           table_o, match, err_cnt)
// -----------------------------------------------------------------------------
module truth_table_probe
    import truth_table_probe_pkg::*;
#(
    parameter int                        N_IN     = 4,
    parameter int                        SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0]      EXPECTED = EXPECTED_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    truth_table_probe_if.slave bus
);
    localparam int TTW   = tt_w(N_IN);
    localparam int CW    = cnt_w(SETTLE);
    localparam int EW    = N_IN + 1;

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_SETTLE = 2'(ST_SETTLE);
    localparam logic [1:0] S_SAMPLE = 2'(ST_SAMPLE);
    localparam logic [1:0] S_DONE   = 2'(ST_DONE);

    // With no settle time every slot is a bare sample cycle.
    localparam logic [1:0] S_SLOT   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    // The timer holds SETTLE-1 so the SETTLE state lasts exactly SETTLE cycles
    // and leaves on the cycle the counter reads zero.
    localparam logic [CW-1:0] LOAD_VAL = CW'((SETTLE > 0) ? (SETTLE - 1) : 0);

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_vec;
    logic [TTW-1:0]  r_table;
    logic [EW-1:0]   r_err;
    logic            r_match;

    logic            w_zero;
    logic            w_load;
    logic            w_dec;
    logic            w_last;
    logic            w_miss;
    logic [EW-1:0]   w_err_nxt;

    assign w_last    = (r_vec == '1);
    assign w_miss    = (bus.resp_i != EXPECTED[r_vec]);
    assign w_err_nxt = r_err + EW'(w_miss);
    assign w_load    = ((r_state == S_IDLE) && bus.start) ||
                       ((r_state == S_SAMPLE) && !w_last);
    assign w_dec     = (r_state == S_SETTLE);

    probe_settle_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_table <= '0;
            r_err   <= '0;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vec <= '0;
                    if (bus.start) begin
                        r_table <= '0;
                        r_err   <= '0;
                        r_match <= 1'b0;
                        r_state <= S_SLOT;
                    end
                end
                S_SETTLE: begin
                    if (w_zero) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_table[r_vec] <= bus.resp_i;
                    r_err          <= w_err_nxt;
                    if (w_last) begin
                        // match must already be valid in the done cycle.
                        r_match <= (w_err_nxt == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        r_state <= S_SLOT;
                    end
                end
                S_DONE: begin
                    r_vec   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.vec_o   = r_vec;
    assign bus.table_o = r_table;
    assign bus.match   = r_match;
    assign bus.err_cnt = r_err;
endmodule

// File: tb/tb_truth_table_probe.sv
module tb_truth_table_probe;
    import truth_table_probe_pkg::*;

    localparam logic [15:0] GATE = 16'h429B;

    typedef struct {
        logic [15:0] tt;
        logic        m;
        logic [4:0]  e;
        int          cyc;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    int   modeA  = 0;   // 0: gate, 1: constant 0, 2: gate through 2-cycle delay

    res_t expA[$], gotA[$], expB[$], gotB[$], expC[$], gotC[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_probe_if #(.N_IN(4)) busA ();
    truth_table_probe_if #(.N_IN(4)) busB ();
    truth_table_probe_if #(.N_IN(2)) busC ();

    truth_table_probe #(.N_IN(4), .SETTLE(2), .EXPECTED(16'h429B)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA));
    truth_table_probe #(.N_IN(4), .SETTLE(0), .EXPECTED(16'h429B)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB));
    truth_table_probe #(.N_IN(2), .SETTLE(2), .EXPECTED(4'h6)) dutC (
        .clk(clk), .rst_n(rst_n), .bus(busC));

    // Gate models
    logic dA1 = 1'b0, dA2 = 1'b0, dB1 = 1'b0, dB2 = 1'b0;
    always @(posedge clk) begin
        dA1 <= GATE[busA.vec_o];
        dA2 <= dA1;
        dB1 <= GATE[busB.vec_o];
        dB2 <= dB1;
    end
    assign busA.resp_i = (modeA == 0) ? GATE[busA.vec_o] :
                         (modeA == 1) ? 1'b0 : dA2;
    assign busB.resp_i = dB2;
    assign busC.resp_i = busC.vec_o[0] ^ busC.vec_o[1];

    // Output monitor: capture every done pulse
    always @(negedge clk) begin : mon
        res_t r;
        if (busA.done === 1'b1) begin
            r.tt = busA.table_o; r.m = busA.match; r.e = busA.err_cnt; r.cyc = cyc;
            gotA.push_back(r);
        end
        if (busB.done === 1'b1) begin
            r.tt = busB.table_o; r.m = busB.match; r.e = busB.err_cnt; r.cyc = cyc;
            gotB.push_back(r);
        end
        if (busC.done === 1'b1) begin
            r.tt = {12'h000, busC.table_o}; r.m = busC.match; r.e = {2'b00, busC.err_cnt}; r.cyc = cyc;
            gotC.push_back(r);
        end
    end

    function automatic res_t mk(input logic [15:0] tt, input logic [15:0] ref_tt, input int done_cyc);
        res_t r;
        r.tt  = tt;
        r.m   = (tt == ref_tt);
        r.e   = 5'($countones(tt ^ ref_tt));
        r.cyc = done_cyc;
        return r;
    endfunction

    // Table a SETTLE=0 probe sees through a 2-cycle delayed gate: each sample
    // reflects the vector driven two cycles earlier (vec_o sat at 0 before).
    function automatic logic [15:0] delayed_tt();
        logic [15:0] t;
        for (int k = 0; k < 16; k++) t[k] = GATE[(k < 2) ? 0 : k - 2];
        return t;
    endfunction

    task automatic kick(input int which, output int t0);
        @(negedge clk);
        case (which)
            0: busA.start = 1'b1;
            1: busB.start = 1'b1;
            default: busC.start = 1'b1;
        endcase
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        busA.start = 1'b0;
        busB.start = 1'b0;
        busC.start = 1'b0;
    endtask

    task automatic wait_res(input int which, output bit ok);
        int n;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            n = (which == 0) ? gotA.size() : (which == 1) ? gotB.size() : gotC.size();
            if (n > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busA.busy, busA.done, busA.match} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b want=000", {busA.busy, busA.done, busA.match});
        end
        checks++;
        if (busA.vec_o !== 4'd0) begin
            errors++; $display("FAIL reset_vec got=%0d want=0", busA.vec_o);
        end
        checks++;
        if (busA.table_o !== 16'h0 || busA.err_cnt !== 5'd0) begin
            errors++; $display("FAIL reset_table got=%h/%0d want=0000/0", busA.table_o, busA.err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Single sweep on instance A with the current model; compares everything.
    task automatic sweep_A(input string nm, input logic [15:0] exp_tt);
        int t0; bit ok; res_t g, x;
        kick(0, t0);
        expA.push_back(mk(exp_tt, GATE, t0 + 48));
        wait_res(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s_timeout got=no_done want=done", nm);
            return;
        end
        g = gotA.pop_front(); x = expA.pop_front();
        checks++; if (g.tt !== x.tt) begin errors++; $display("FAIL %s_table got=%h want=%h", nm, g.tt, x.tt); end
        checks++; if (g.m !== x.m) begin errors++; $display("FAIL %s_match got=%b want=%b", nm, g.m, x.m); end
        checks++; if (g.e !== x.e) begin errors++; $display("FAIL %s_errcnt got=%0d want=%0d", nm, g.e, x.e); end
        checks++; if (g.cyc !== x.cyc) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", nm, g.cyc - t0, x.cyc - t0); end
    endtask

    task automatic test_gate();
        modeA = 0;
        sweep_A("gate", GATE);
    endtask

    task automatic test_const_zero();
        modeA = 1;
        sweep_A("const0", 16'h0000);
        modeA = 0;
    endtask

    task automatic test_delay();
        int t0; bit ok; res_t g, x;
        kick(1, t0);
        expB.push_back(mk(delayed_tt(), GATE, t0 + 16));
        wait_res(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL delay0_timeout got=no_done want=done");
        end else begin
            g = gotB.pop_front(); x = expB.pop_front();
            checks++; if (g.tt !== x.tt) begin errors++; $display("FAIL delay0_table got=%h want=%h", g.tt, x.tt); end
            checks++; if (g.m !== 1'b0 || g.m !== x.m) begin errors++; $display("FAIL delay0_match got=%b want=%b", g.m, x.m); end
            checks++; if (g.cyc !== x.cyc) begin errors++; $display("FAIL delay0_latency got=%0d want=%0d", g.cyc - t0, x.cyc - t0); end
        end
        modeA = 2;
        sweep_A("delay2", GATE);
        modeA = 0;
    endtask

    task automatic test_back_to_back();
        int t0, t1, steps, bad, idle; logic [3:0] last; bit ok; res_t g, x;
        modeA = 0;
        @(negedge clk);
        busA.start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        expA.push_back(mk(GATE, GATE, t0 + 48));
        last = 4'd0; steps = 0; bad = 0; idle = 0; ok = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            #1;
            if (gotA.size() > 0) begin ok = 1'b1; break; end
            if (busA.busy !== 1'b1) idle++;
            if (busA.vec_o !== last) begin
                if (busA.vec_o !== last + 4'd1) bad++;
                steps++;
                last = busA.vec_o;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout got=no_done want=done");
            busA.start = 1'b0;
            return;
        end
        checks++; if (steps != 15 || bad != 0) begin errors++; $display("FAIL b2b_vecseq got=steps%0d_bad%0d want=steps15_bad0", steps, bad); end
        checks++; if (idle != 0) begin errors++; $display("FAIL b2b_busy got=%0d_low_cycles want=0", idle); end
        checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_in_done got=%b want=0", busA.busy); end
        g = gotA.pop_front(); x = expA.pop_front();
        checks++; if (g.tt !== x.tt || g.m !== x.m) begin errors++; $display("FAIL b2b_table got=%h/%b want=%h/%b", g.tt, g.m, x.tt, x.m); end
        checks++; if (g.cyc !== x.cyc) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", g.cyc - t0, x.cyc - t0); end
        // start still high: ignored in DONE, accepted in the following IDLE cycle
        @(negedge clk);
        #1;
        checks++; if (busA.busy !== 1'b0 || gotA.size() != 0) begin errors++; $display("FAIL b2b_idle got=busy%b_dones%0d want=busy0_dones0", busA.busy, gotA.size()); end
        @(posedge clk);
        #1 t1 = cyc;
        expA.push_back(mk(GATE, GATE, t1 + 48));
        @(negedge clk);
        busA.start = 1'b0;
        checks++; if (busA.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b want=1", busA.busy); end
        wait_res(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b2_timeout got=no_done want=done");
            return;
        end
        g = gotA.pop_front(); x = expA.pop_front();
        checks++; if (g.tt !== x.tt || g.cyc !== x.cyc) begin errors++; $display("FAIL b2b2_result got=%h@%0d want=%h@%0d", g.tt, g.cyc - t1, x.tt, x.cyc - t1); end
    endtask

    task automatic test_reset_mid();
        int t0; bit ok;
        modeA = 0;
        kick(0, t0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busA.vec_o === 4'd7) begin ok = 1'b1; break; end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_reach7 got=%0d want=7", busA.vec_o);
            return;
        end
        checks++; if (busA.table_o !== 16'h001B) begin errors++; $display("FAIL rstmid_partial got=%h want=001b", busA.table_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (busA.busy !== 1'b0 || busA.vec_o !== 4'd0) begin errors++; $display("FAIL rstmid_async got=busy%b_vec%0d want=busy0_vec0", busA.busy, busA.vec_o); end
        checks++; if (busA.table_o !== 16'h0 || busA.err_cnt !== 5'd0) begin errors++; $display("FAIL rstmid_table got=%h/%0d want=0000/0", busA.table_o, busA.err_cnt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (gotA.size() != 0) begin errors++; $display("FAIL rstmid_nodone got=%0d want=0", gotA.size()); end
        sweep_A("rstmid_clean", GATE);
    endtask

    task automatic test_nin2();
        int t0; bit ok; res_t g, x;
        kick(2, t0);
        expC.push_back(mk(16'h0006, 16'h0006, t0 + 12));
        wait_res(2, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL nin2_timeout got=no_done want=done");
            return;
        end
        g = gotC.pop_front(); x = expC.pop_front();
        checks++; if (g.tt !== x.tt) begin errors++; $display("FAIL nin2_table got=%h want=%h", g.tt, x.tt); end
        checks++; if (g.m !== x.m || g.e !== x.e) begin errors++; $display("FAIL nin2_match got=%b/%0d want=%b/%0d", g.m, g.e, x.m, x.e); end
        checks++; if (g.cyc !== x.cyc) begin errors++; $display("FAIL nin2_latency got=%0d want=%0d", g.cyc - t0, x.cyc - t0); end
    endtask

    initial begin
        busA.start = 1'b0;
        busB.start = 1'b0;
        busC.start = 1'b0;
        test_reset();
        test_gate();
        test_const_zero();
        test_delay();
        test_back_to_back();
        test_reset_mid();
        test_nin2();
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation watchdog expired");
    end
endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential characterizer for the single-output combinational gate netlists in the design library. It drives every input combination of a gate under test, waits a programmable settle time, samples the gate output and assembles the 2^N-bit truth table. It then compares the result against an expected hex code such as 16'h429B. It sits on the input side of a gate netlist, closing the loop that the synthesized gate opens, and is used for on-chip or in-bench equivalence checking of the generated designs.

## Interface
- N_IN, default 4: number of gate inputs; 1..6.
- SETTLE, default 2: idle cycles between driving a vector and sampling; 0..255.
- EXPECTED, default 16'h429B: reference truth table, width 2^N_IN.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- busy  out  1  high from the start-accept edge until done.
- done  out  1  one-cycle pulse; table_o and match are valid.
- vec_o  out  N_IN  gate input vector; vec_o[0] drives gate input 0.
- resp_i  in  1  gate output.
- table_o  out  2^N_IN  bit k = gate output for vec_o == k.
- match  out  1  table_o == EXPECTED; meaningful once done has pulsed.
- err_cnt  out  N_IN+1  popcount(table_o ^ EXPECTED).

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: vec_o=0, busy=0. start=1 → clear table_o, err_cnt=0, match=0; vec_o=0, settle counter=SETTLE; go to SETTLE, or to SAMPLE if SETTLE=0.
- SETTLE: counter decrements each cycle; at 1 go to SAMPLE.
- SAMPLE: one cycle. On its edge:
  - table_o[vec_o] ← resp_i.
  - If resp_i ≠ EXPECTED[vec_o], err_cnt increments.
  - If vec_o == 2^N_IN−1 go to DONE; otherwise vec_o increments and the FSM returns to SETTLE (or SAMPLE if SETTLE=0).
- DONE: one cycle. done=1, match=(err_cnt==0), busy=0. Then IDLE.
- vec_o returns to 0 in IDLE. table_o, match and err_cnt hold until the next accepted start.
- start while busy is ignored; there is no queueing.
- start high in the DONE cycle is ignored. It is accepted on the following IDLE cycle if still high.
- resp_i is sampled raw. The gate sits in the clk domain, so there is no synchronizer.
- Counter widths:
  - vec_o wraps only via the DONE→IDLE transition, never mid-sweep.
  - err_cnt saturates naturally at 2^N_IN, which fits in N_IN+1 bits.

## Timing
- Reset values: busy=0, done=0, vec_o=0, table_o=0, match=0, err_cnt=0, state=IDLE.
- Each vector occupies SETTLE+1 cycles. resp_i is sampled on the last edge of the slot.
- Start-accept edge to done high: 2^N_IN·(SETTLE+1) cycles. Defaults give 48.
- Next start is accepted at the earliest 2 cycles after the done cycle begins.
- rst_n low mid-sweep: all outputs return to reset values asynchronously; the partial table is discarded.
- rst_n deassertion is synchronized externally. The block samples start from the first edge after release.

## Structure
- Package truth_table_probe_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - localparam helpers TT_W = 2**N_IN and CNT_W = $clog2(SETTLE+1);
  - default EXPECTED constant.
- One natural sub-module, probe_settle_timer: a loadable down-counter with a zero flag, reused by the FSM for every vector slot.
- Everything else, including the FSM, vector counter and table shift/compare, lives in the top module.

## Test plan
- Bench models gate 0x429B on vec_o; pulse start with defaults → done at cycle 48, table_o=16'h429B, match=1, err_cnt=0.
- Model outputs constant 0 → table_o=16'h0000, match=0, err_cnt=7, the popcount of 16'h429B.
- Model uses a 2-cycle registered delay with SETTLE=0 → the table is corrupted (shifted-sample pattern) and match=0. Rerun with SETTLE=2 → table_o=16'h429B, match=1.
- Assert start every cycle during a sweep → exactly one done pulse per sweep; busy stays high continuously; vec_o sequence is 0..15 with no repeats.
- Pull rst_n low at vector 7 → busy, vec_o and table_o go to 0 immediately with no done. After release, start → a full clean sweep gives 16'h429B.
- N_IN=2, EXPECTED=4'h6 with an XOR model → done after 4·(SETTLE+1)=12 cycles, table_o=4'h6, match=1.
